// File: rtl/oeb_pipe.sv
// oeb_pipe: two-stage carry-save resolve and error/step-scaled-error pipeline
// with valid/ready flow control and a windowed |E| convergence monitor.
module oeb_pipe #(
  parameter int WIDTH    = 10,
  parameter int SAT      = 1,
  parameter int MU_SHIFT = 2,
  parameter int WIN_LOG2 = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [WIDTH-1:0]       sum,
  input  logic signed [WIDTH-1:0]       carry,
  input  logic signed [WIDTH-1:0]       D,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [WIDTH-1:0]       Y,
  output logic signed [WIDTH-1:0]       E,
  output logic signed [WIDTH-1:0]       E_mu,
  output logic                          sat,
  input  logic [WIDTH+WIN_LOG2-1:0]     thresh,
  output logic [WIDTH+WIN_LOG2-1:0]     err_acc,
  output logic                          win_done,
  output logic                          conv
);
  localparam int AW = WIDTH + WIN_LOG2;
  localparam logic [WIDTH:0] RND = (WIDTH+1)'((2**MU_SHIFT) / 2);

  // Returns {clamp_flag, value}; the flag can only be set when SAT is enabled.
  function automatic logic [WIDTH:0] clamp(input logic [WIDTH:0] x);
    logic ovf;
    ovf = (SAT != 0) && (x[WIDTH] ^ x[WIDTH-1]);
    return ovf ? (x[WIDTH] ? {2'b11, {(WIDTH-1){1'b0}}} : {2'b10, {(WIDTH-1){1'b1}}})
               : {1'b0, x[WIDTH-1:0]};
  endfunction

  logic                    r_v1, r_s1;
  logic [WIDTH-1:0]        r_y1, r_d1;
  logic [WIN_LOG2-1:0]     r_cnt;
  logic [AW-1:0]           r_run;
  logic [WIDTH:0]          w_y1c, w_ec, w_ex;
  logic signed [WIDTH:0]   w_rnd, w_sh;
  logic [WIDTH-1:0]        w_e, w_abs;
  logic [AW-1:0]           w_acc;
  logic                    w_hs, w_last;

  assign in_ready = !out_valid || out_ready;
  assign w_y1c    = clamp({sum[WIDTH-1], sum} + {carry[WIDTH-1], carry});
  assign w_ex     = {r_d1[WIDTH-1], r_d1} - {r_y1[WIDTH-1], r_y1};
  assign w_ec     = clamp(w_ex);
  assign w_e      = w_ec[WIDTH-1:0];
  assign w_rnd    = {w_e[WIDTH-1], w_e} + RND;
  assign w_sh     = w_rnd >>> MU_SHIFT;
  assign w_hs     = out_valid && out_ready;
  assign w_last   = &r_cnt;
  assign w_abs    = E[WIDTH-1] ? -E : E;
  assign w_acc    = r_run + AW'(w_abs);
  assign win_done = w_hs && w_last && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1      <= 1'b0;
      r_s1      <= 1'b0;
      r_y1      <= '0;
      r_d1      <= '0;
      out_valid <= 1'b0;
      Y         <= '0;
      E         <= '0;
      E_mu      <= '0;
      sat       <= 1'b0;
      r_cnt     <= '0;
      r_run     <= '0;
      err_acc   <= '0;
      conv      <= 1'b0;
    end else begin
      if (in_ready) begin
        r_v1      <= in_valid;
        r_y1      <= w_y1c[WIDTH-1:0];
        r_s1      <= w_y1c[WIDTH];
        r_d1      <= D;
        out_valid <= r_v1;
        Y         <= r_y1;
        E         <= w_e;
        E_mu      <= w_sh[WIDTH-1:0];
        sat       <= r_s1 | w_ec[WIDTH];
      end
      if (w_hs) begin
        r_cnt <= r_cnt + 1'b1;
        r_run <= w_last ? '0 : w_acc;
        if (w_last) begin
          err_acc <= w_acc;
          conv    <= (w_acc < thresh);
        end
      end
    end
  end
endmodule

// File: tb/tb_oeb_pipe.sv
// tb_oeb_pipe: directed checks of the output-error pipeline, flow control,
// saturation (SAT=1 and SAT=0 instances) and the convergence monitor.
module tb_oeb_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, in_valid, out_ready;
  logic signed [9:0] sum, carry, D;
  logic [13:0]       thresh;
  logic              in_ready, out_valid, sat, win_done, conv;
  logic signed [9:0] Y, E, E_mu;
  logic [13:0]       err_acc;
  logic              z_in_ready, z_out_valid, z_sat, z_win_done, z_conv;
  logic signed [9:0] z_Y, z_E, z_E_mu;
  logic [13:0]       z_err_acc;
  int n_pass = 0, n_chk = 0;

  oeb_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .carry(carry), .D(D), .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .E(E), .E_mu(E_mu), .sat(sat), .thresh(thresh),
    .err_acc(err_acc), .win_done(win_done), .conv(conv)
  );

  oeb_pipe #(.SAT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(z_in_ready),
    .sum(sum), .carry(carry), .D(D), .out_valid(z_out_valid), .out_ready(out_ready),
    .Y(z_Y), .E(z_E), .E_mu(z_E_mu), .sat(z_sat), .thresh(thresh),
    .err_acc(z_err_acc), .win_done(z_win_done), .conv(z_conv)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input int s, input int c, input int d);
    in_valid = 1'b1;
    sum      = 10'(s);
    carry    = 10'(c);
    D        = 10'(d);
    tick;
    in_valid = 1'b0;
    tick;
  endtask

  // Streams n samples with Y=0 and E alternating +mag/-mag, then drains.
  task automatic run_window(input int n, input int mag, output int hs, output int pulses, output int pulse_at);
    int sent;
    sent = 0; hs = 0; pulses = 0; pulse_at = -1;
    for (int c = 0; c < n + 10; c++) begin
      out_ready = 1'b1;
      in_valid  = (sent < n);
      sum       = '0;
      carry     = '0;
      D         = 10'(sent % 2 ? -mag : mag);
      #1;
      if (out_valid && out_ready) begin
        hs++;
        if (win_done) begin
          pulses++;
          pulse_at = hs;
        end
      end
      if (in_valid && in_ready) sent++;
      tick;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int got, sent, hs, p, pa;
    rst       = 1'b1;
    out_ready = 1'b1;
    thresh    = 14'd100;
    in_valid  = 1'($urandom);
    sum       = 10'($urandom);
    carry     = 10'($urandom);
    D         = 10'($urandom);
    tick;
    in_valid  = 1'($urandom);
    sum       = 10'($urandom);
    tick;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_Y", Y, 0);
    chk("rst_E", E, 0);
    chk("rst_E_mu", E_mu, 0);
    chk("rst_sat", sat, 0);
    chk("rst_err_acc", err_acc, 0);
    chk("rst_conv", conv, 0);
    chk("rst_win_done", win_done, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    send_one(100, 23, 200);
    chk("basic_valid", out_valid, 1);
    chk("basic_Y", Y, 123);
    chk("basic_E", E, 77);
    chk("basic_E_mu", E_mu, 19);
    chk("basic_sat", sat, 0);

    send_one(-50, -3, -60);
    chk("neg_Y", Y, -53);
    chk("neg_E", E, -7);
    chk("neg_E_mu", E_mu, -2);
    chk("neg_sat", sat, 0);

    send_one(400, 300, -512);
    chk("sat1_Y", Y, 511);
    chk("sat1_E", E, -512);
    chk("sat1_E_mu", E_mu, -128);
    chk("sat1_sat", sat, 1);
    chk("sat0_Y", z_Y, -324);
    chk("sat0_E", z_E, -188);
    chk("sat0_E_mu", z_E_mu, -47);
    chk("sat0_sat", z_sat, 0);

    tick;
    chk("bubble_valid", out_valid, 0);

    got = 0;
    sent = 0;
    for (int k = 0; k < 40 && got < 8; k++) begin
      out_ready = !(k >= 3 && k <= 5);
      in_valid  = (sent < 8);
      sum       = 10'(10 * sent);
      carry     = 10'(sent);
      D         = 10'(3 * sent);
      #1;
      if (k < 8) chk("bp_in_ready", in_ready, (k >= 3 && k <= 5) ? 0 : 1);
      if (out_valid) begin
        chk("bp_Y", Y, 11 * got);
        chk("bp_E", E, -8 * got);
        if (out_ready) got++;
      end
      if (in_valid && in_ready) sent++;
      tick;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", got, 8);

    rst = 1'b1;
    tick;
    rst = 1'b0;
    run_window(16, 5, hs, p, pa);
    chk("w1_handshakes", hs, 16);
    chk("w1_pulses", p, 1);
    chk("w1_pulse_at", pa, 16);
    chk("w1_err_acc", err_acc, 80);
    chk("w1_conv", conv, 1);

    run_window(16, 10, hs, p, pa);
    chk("w2_pulses", p, 1);
    chk("w2_err_acc", err_acc, 160);
    chk("w2_conv", conv, 0);

    run_window(7, 3, hs, p, pa);
    chk("mid_handshakes", hs, 7);
    chk("mid_pulses", p, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_rst_err_acc", err_acc, 0);
    chk("mid_rst_conv", conv, 0);
    run_window(16, 1, hs, p, pa);
    chk("w3_pulses", p, 1);
    chk("w3_pulse_at", pa, 16);
    chk("w3_err_acc", err_acc, 16);
    chk("w3_conv", conv, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
